// File: rtl/ifetch_unit.sv
// Instruction fetch unit: fetch_pc register feeding a 2-entry prefetch FIFO of {instr, pc}.
// Optional stall-cycle performance counter guarded by IFETCH_PERF_EN.
`ifndef MEMADDRSIZE
`define MEMADDRSIZE 8
`endif
`ifndef DATASIZE
`define DATASIZE 32
`endif

module ifetch_unit #(
  parameter logic [`MEMADDRSIZE-1:0] RESET_PC  = '0,
  parameter int                      MEM_WORDS = 31
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [`MEMADDRSIZE-1:0] imem_addr,
  input  logic [`DATASIZE-1:0]    imem_data,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [`MEMADDRSIZE-1:0] redirect_pc,
  output logic [`DATASIZE-1:0]    instr,
  output logic [`MEMADDRSIZE-1:0] instr_pc,
  output logic                    instr_valid,
`ifdef IFETCH_PERF_EN
  output logic [15:0]             perf_stall_cnt,
`endif
  output logic                    fetch_done
);

  localparam int AW = `MEMADDRSIZE;
  localparam int DW = `DATASIZE;
  localparam logic [AW-1:0] LAST_PC = AW'(MEM_WORDS - 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t        slot0, slot1;   // slot0 is always the head
  entry_t        new_ent;
  logic [1:0]    count;
  logic [AW-1:0] fetch_pc;
  logic          halted;
  logic          pop, push;

  assign new_ent.data = imem_data;
  assign new_ent.pc   = fetch_pc;

  assign pop  = (count != 2'd0) && !stall && !redirect;
  assign push = !redirect && !halted && (!count[1] || pop);

  assign imem_addr   = fetch_pc;
  assign instr       = slot0.data;
  assign instr_pc    = slot0.pc;
  assign instr_valid = (count != 2'd0);
  assign fetch_done  = halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0    <= '0;
      slot1    <= '0;
      count    <= 2'd0;
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
    end else if (redirect) begin
      slot0    <= '0;
      slot1    <= '0;
      count    <= 2'd0;
      fetch_pc <= redirect_pc;
      halted   <= (32'(redirect_pc) >= 32'(MEM_WORDS));
    end else begin
      // Shift-style FIFO: a pop moves slot1 to the head, push lands behind the survivors.
      case ({push, pop})
        2'b11: begin
          if (count == 2'd1) slot0 <= new_ent;
          else begin
            slot0 <= slot1;
            slot1 <= new_ent;
          end
        end
        2'b10: begin
          if (count == 2'd0) slot0 <= new_ent;
          else               slot1 <= new_ent;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
      if (push) begin
        if (fetch_pc == LAST_PC) halted <= 1'b1;
        else                     fetch_pc <= fetch_pc + AW'(1);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_stall_cnt <= 16'd0;
    else if (instr_valid && stall && perf_stall_cnt != 16'hFFFF)
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-002 Parameter MEM_WORDS, default 31: number of valid instruction words; legal addresses are 0..MEM_WORDS-1.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port imem_addr  output  `memaddrsize  fetch address driven to instruction memory; equals fetch_pc.
REQ-006 Port imem_data  input  `datasize  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 Port stall  input  1  downstream not accepting; instr held while high.
REQ-008 Port redirect  input  1  branch/flush request; single-cycle pulse.
REQ-009 Port redirect_pc  input  `memaddrsize  new fetch address, sampled when redirect=1.
REQ-010 Port instr  output  `datasize  instruction at FIFO head.
REQ-011 Port instr_pc  output  `memaddrsize  address of instr.
REQ-012 Port instr_valid  output  1  instr/instr_pc hold a valid entry.
REQ-013 Port fetch_done  output  1  no further fetches until redirect.

Function
REQ-014 Block SHALL contain a 2-entry prefetch FIFO of {instruction, pc}, a fetch_pc register, a 2-bit occupancy count and a halted flag.
REQ-015 instr, instr_pc SHALL be registered FIFO head contents; instr_valid SHALL equal (count != 0).
REQ-016 Pop SHALL occur on an edge where instr_valid=1 and stall=0 and redirect=0.
REQ-017 Push SHALL occur on an edge where redirect=0, halted=0, and (count<2 or pop in that edge); it SHALL store {imem_data, fetch_pc} and increment fetch_pc by 1.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and preserve ordering; with count=2 and no pop, no push and fetch_pc held.
REQ-019 On a push where fetch_pc = MEM_WORDS-1, halted SHALL set; fetch_pc SHALL not wrap.
REQ-020 fetch_done SHALL equal halted (registered).
REQ-021 Redirect SHALL have priority over push and pop: on that edge count<=0, fetch_pc<=redirect_pc, halted<=(redirect_pc >= MEM_WORDS); FIFO contents discarded.
REQ-022 Redirect latency: redirect at edge N -> imem_addr=redirect_pc in cycle after N -> instr_valid=1 with instr_pc=redirect_pc after edge N+1 (stall ignored for this first push).
REQ-023 Stall SHALL not affect fetching while FIFO has space; under continuous stall exactly 2 entries fill then fetch_pc freezes.
REQ-024 Steady state with stall=0 SHALL deliver one instruction per cycle in ascending pc order.

Reset
REQ-025 rst_n=0 SHALL immediately set fetch_pc=RESET_PC, count=0, halted=0, FIFO entries=0; thus instr=0, instr_pc=0, instr_valid=0, fetch_done=0.
REQ-026 First push SHALL occur on the first rising edge with rst_n=1; instr_valid=1 after that edge.
REQ-027 Reset asserted mid-operation SHALL discard all FIFO entries and pending redirect.

Configuration
REQ-028 Macro IFETCH_PERF_EN: when defined, block SHALL add output perf_stall_cnt, 16 bits, counting cycles with instr_valid=1 and stall=1, saturating at 0xFFFF, cleared by reset only.
REQ-029 When IFETCH_PERF_EN undefined, port perf_stall_cnt and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset release, mem[i]=0x100+i, stall=0 -> instr_pc 0,1,2,... one per cycle, instr=0x100,0x101,...; fetch_done=1 after pc 30 pushed; pc 30 last valid.
REQ-031 Stall held high 5 cycles from reset -> instr_pc=0 held, count=2, imem_addr frozen at 2; stall low -> pcs 0,1,2 consecutive, no gap or duplicate.
REQ-032 redirect=1, redirect_pc=7 while count=2 -> next cycle instr_valid=0, imem_addr=7; following cycle instr_pc=7, instr=0x107.
REQ-033 redirect with redirect_pc=31 -> instr_valid=0, fetch_done=1 next cycle, no pushes; redirect_pc=3 later -> resumes at pc 3, fetch_done=0.
REQ-034 rst_n asserted asynchronously mid-cycle with count=2 -> outputs zero before next edge; restart at RESET_PC.
REQ-035 With IFETCH_PERF_EN: 10 stall cycles with instr_valid=1 -> perf_stall_cnt=10; forced 70000 stall cycles -> 0xFFFF.
